boot_loader: RTL
================

# boot_loader

Byte-stream program loader that sits directly upstream of `top` and drives its memory port B (`web`, `addrb`, `dinb`). It receives a framed image over a valid/ready byte interface, such as a UART receiver, and writes it word by word into memory. It holds the core in reset for the whole load and releases it only after a frame passes its checksum.

## Interface
Parameters:
- `SYNC_BYTE`, default `8'hA5`: frame start marker.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_data`, input, 8: incoming byte.
- `rx_valid`, input, 1: `rx_data` is valid.
- `rx_ready`, output, 1: the loader accepts the byte this cycle.
- `web`, output, 4: port-B byte write enables, `4'b1111` for one cycle per word.
- `addrb`, output, 32: port-B byte address.
- `dinb`, output, 32: port-B write data.
- `core_rst_n`, output, 1: active-low reset to `top`.
- `done`, output, 1: last frame loaded successfully.
- `err`, output, 1: last frame failed.

## Operation
Frame format, all fields little-endian:
- `SYNC_BYTE`
- 4-byte base address
- 2-byte word count N
- N × 4 data bytes
- 1 checksum byte, equal to the XOR of every byte after sync up to and including the last data byte.

A byte is accepted when `rx_valid && rx_ready`. The loader uses these states:
- **IDLE:** accepted bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` → ADDR, clear checksum accumulator.
- **ADDR:** collect 4 bytes. After the 4th byte:
  - if `addr[1:0] != 0` → ERR;
  - otherwise → COUNT.
- **COUNT:** collect 2 bytes. After the 2nd byte:
  - if N == 0 → CHK;
  - otherwise → DATA.
- **DATA:** assemble each word from 4 bytes, first byte = bits [7:0]. On the 4th byte, issue one write to the current address, then increment the address by 4 (modulo 2^32, wrap-around permitted) and decrement the remaining count. When the remaining count reaches 0 → CHK.
- **CHK:** one byte.
  - match → DONE;
  - mismatch → ERR.
- **DONE:** `done=1`, `core_rst_n=1`. Accepted `SYNC_BYTE` → ADDR, with `done` and `core_rst_n` cleared in the same transition. Other bytes are discarded.
- **ERR:** `err=1`, `core_rst_n=0`. Accepted `SYNC_BYTE` → ADDR, clear `err`. Other bytes are discarded.

Additional rules:
- `core_rst_n=0` in every state except DONE. The core never runs a partially loaded image.
- Memory writes already issued are not rolled back on ERR.
- The checksum accumulator covers address, count and data bytes only, not the sync byte or the checksum byte itself.

## Timing
Reset values after a cycle with `rst=1`:
- `web=0`, `addrb=0`, `dinb=0`
- `core_rst_n=0`, `done=0`, `err=0`
- state IDLE
- `rx_ready=0` during the reset cycle.

Cycle behaviour:
- `rx_ready = !rst && (web == 0)`. There is a one-cycle bubble during each write cycle; otherwise one byte per cycle is accepted.
- Write latency: `web=4'b1111`, `addrb` and `dinb` are registered and valid in the cycle after the 4th byte of a word is accepted. `web` returns to 0 the next cycle. `addrb` and `dinb` hold their last value.
- `done`/`core_rst_n` rise in the cycle after an accepted, matching checksum byte.
- `err` rises in the cycle after the offending byte: the 4th address byte, or the checksum byte.
- `rst` asserted mid-frame aborts the load on that edge with all outputs at their reset values. No further writes occur.
- The maximum frame is 65535 words. The count is not bounds-checked against memory size.

## Test plan
- **Single word:** `A5 00 08 00 00 01 00 44 55 00 00 18` with `rx_valid` held high → exactly one cycle of `web=1111`, `addrb=0x800`, `dinb=0x00005544`. Then `done=1` and `core_rst_n=1` one cycle after byte `18`, with `err=0`.
- **Zero count:** `A5 00 00 00 00 00 00 00` → no `web` pulse, then `done=1`.
- **Bad checksum:** the single-word frame with a final byte of `19` → the write still occurs, then `err=1` and `core_rst_n` stays 0. A following valid frame → `err` clears and `done=1`.
- **Misalignment and discard:** address `02 08 00 00` → `err=1` the cycle after the 4th address byte, with no writes. Bytes `00 FF` sent in IDLE before a valid frame are ignored.
- **Wrap-around:** base `0xFFFFFFFC`, N=2 → writes at `0xFFFFFFFC` then `0x00000000`. `rx_ready` is low exactly in each write cycle.
- **Reset mid-load:** `rst` pulsed after 2 data bytes → all outputs return to reset values and there are no writes. A subsequent full frame loads correctly.

Source files
------------

// File: rtl/boot_loader.sv
// Framed byte-stream loader: writes a checksummed image into memory port B
// and holds the core in reset until a complete frame has been verified.
module boot_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic [31:0] dinb,
  output logic        core_rst_n,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [3:0]  web_q, web_d;
  logic [31:0] addrb_q, addrb_d;
  logic [31:0] dinb_q, dinb_d;
  logic        accept;

  // A write cycle stalls the byte stream for exactly one cycle.
  assign rx_ready = !rst && (web_q == 4'b0000);
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      web_q   <= 4'b0000;
      addrb_q <= 32'd0;
      dinb_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      web_q   <= web_d;
      addrb_q <= addrb_d;
      dinb_q  <= dinb_d;
    end
  end

  // Field assembly registers are (re)initialised by the frame itself.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
    word_q <= word_d;
    csum_q <= csum_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    web_d   = 4'b0000;
    addrb_d = addrb_q;
    dinb_d  = dinb_q;

    if (accept) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_ADDR;
            idx_d   = 2'd0;
            csum_d  = 8'd0;
          end
        end

        S_ADDR: begin
          addr_d = {rx_data, addr_q[31:8]};
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = (addr_d[1:0] != 2'b00) ? S_ERR : S_COUNT;
          end
        end

        S_COUNT: begin
          cnt_d  = {rx_data, cnt_q[15:8]};
          csum_d = csum_q ^ rx_data;
          if (idx_q == 2'd1) begin
            idx_d   = 2'd0;
            state_d = (cnt_d == 16'd0) ? S_CHK : S_DATA;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end

        S_DATA: begin
          word_d = {rx_data, word_q[23:8]};
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            web_d   = 4'b1111;
            addrb_d = addr_q;
            dinb_d  = {rx_data, word_q};
            addr_d  = addr_q + 32'd4;
            cnt_d   = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_d = S_CHK;
            end
          end
        end

        S_CHK: begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign web        = web_q;
  assign addrb      = addrb_q;
  assign dinb       = dinb_q;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign core_rst_n = (state_q == S_DONE);

endmodule
